// File: rtl/program_loader.sv
// Streams a byte-serial program image into memory as big-endian words,
// then releases the core from reset; residual bytes use half/byte writes.
module program_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MEM_SIZE_BYTES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] mem_data_addr,
    output logic [31:0] mem_data_wdata,
    output logic [1:0]  mem_data_size,
    output logic        mem_data_we,
    output logic        mem_data_req,
    input  logic        mem_data_ack,
    input  logic [31:0] mem_data_rdata,
    output logic        core_rst,
    output logic        done,
    output logic        error,
    output logic [31:0] byte_count
);

    typedef enum logic [2:0] {
        IDLE, COLLECT, WR_WORD, WR_HALF, WR_BYTE, DONE, ERR
    } state_t;

    localparam logic [32:0] MEM_LIM = 33'(MEM_SIZE_BYTES);

    function automatic logic fits(input logic [31:0] a, input logic [2:0] n);
        return ({1'b0, a} + {30'h0, n}) <= MEM_LIM;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        req_q, req_d;
    logic [23:0] buf_q, buf_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        pend_q, pend_d;
    logic [7:0]  pend_byte_q, pend_byte_d;
    logic [31:0] byte_count_q, byte_count_d;

    logic        issue;
    logic [2:0]  wr_n;
    state_t      wr_state;
    logic [2:0]  size_bytes;
    logic        unused_rdata;

    assign unused_rdata = ^mem_data_rdata;
    assign size_bytes   = (size_q == 2'b10) ? 3'd4 :
                          (size_q == 2'b01) ? 3'd2 : 3'd1;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        req_d        = req_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        pend_d       = pend_q;
        pend_byte_d  = pend_byte_q;
        byte_count_d = byte_count_q;
        issue        = 1'b0;
        wr_n         = 3'd0;
        wr_state     = ERR;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d      = COLLECT;
                    addr_d       = BASE_ADDR;
                    byte_count_d = '0;
                    cnt_d        = '0;
                    last_d       = 1'b0;
                    pend_d       = 1'b0;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    cnt_d = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0: buf_d[23:16] = in_data;
                        2'd1: buf_d[15:8]  = in_data;
                        2'd2: buf_d[7:0]   = in_data;
                        default: begin
                            wdata_d  = {buf_q, in_data};
                            size_d   = 2'b10;
                            wr_n     = 3'd4;
                            wr_state = WR_WORD;
                            issue    = 1'b1;
                            last_d   = in_last;
                        end
                    endcase
                    if (in_last && cnt_q != 2'd3) begin
                        cnt_d    = '0;
                        issue    = 1'b1;
                        size_d   = 2'b01;
                        wr_n     = 3'd2;
                        wr_state = WR_HALF;
                        case (cnt_q)
                            2'd0: begin
                                wdata_d  = {24'h0, in_data};
                                size_d   = 2'b00;
                                wr_n     = 3'd1;
                                wr_state = WR_BYTE;
                            end
                            2'd1: wdata_d = {16'h0, buf_q[23:16], in_data};
                            default: begin
                                // third byte waits for the half write to finish
                                wdata_d     = {16'h0, buf_q[23:8]};
                                pend_d      = 1'b1;
                                pend_byte_d = in_data;
                            end
                        endcase
                    end
                    if (issue) begin
                        if (fits(addr_q, wr_n)) begin
                            state_d = wr_state;
                            req_d   = 1'b1;
                        end else begin
                            state_d = ERR;
                        end
                    end
                end
            end
            WR_WORD, WR_HALF, WR_BYTE: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (mem_data_ack) begin
                    req_d        = 1'b0;
                    addr_d       = addr_q + {29'h0, size_bytes};
                    byte_count_d = byte_count_q + {29'h0, size_bytes};
                    state_d      = DONE;
                    if (state_q == WR_WORD && !last_q) state_d = COLLECT;
                    if (state_q == WR_HALF && pend_q) begin
                        // req stays low one cycle before the trailing byte
                        pend_d  = 1'b0;
                        wdata_d = {24'h0, pend_byte_q};
                        size_d  = 2'b00;
                        state_d = fits(addr_q + 32'd2, 3'd1) ? WR_BYTE : ERR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            req_q        <= 1'b0;
            buf_q        <= '0;
            cnt_q        <= '0;
            last_q       <= 1'b0;
            pend_q       <= 1'b0;
            pend_byte_q  <= '0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            req_q        <= req_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            pend_q       <= pend_d;
            pend_byte_q  <= pend_byte_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign in_ready       = (state_q == COLLECT);
    assign core_rst       = (state_q != DONE);
    assign done           = (state_q == DONE);
    assign error          = (state_q == ERR);
    assign mem_data_req   = req_q;
    assign mem_data_we    = req_q;
    assign mem_data_addr  = addr_q;
    assign mem_data_wdata = wdata_q;
    assign mem_data_size  = size_q;
    assign byte_count     = byte_count_q;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the first memory byte written; BASE_ADDR[1:0] SHALL be 0.
REQ-003 The block SHALL have parameter MEM_SIZE_BYTES, default 65536, meaning the highest writable address is MEM_SIZE_BYTES-1.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte, program order
- in_last  in  1  marks the final byte of the image
- in_ready  out  1  loader accepts the byte this cycle
- mem_data_addr  out  32  data-port byte address
- mem_data_wdata  out  32  write data, right-justified
- mem_data_size  out  2  00 byte, 01 halfword, 10 word
- mem_data_we  out  1  write enable, always 1 while req is high
- mem_data_req  out  1  transfer request
- mem_data_ack  in  1  transfer complete
- mem_data_rdata  in  32  unused; SHALL be ignored
- core_rst  out  1  holds the core in reset (active-high)
- done  out  1  load completed successfully (sticky)
- error  out  1  load aborted (sticky)
- byte_count  out  32  bytes committed to memory

Function
REQ-005 The FSM SHALL have the states IDLE, COLLECT, WR_WORD, WR_HALF, WR_BYTE, DONE and ERR.
REQ-006 IDLE SHALL behave as follows:
- in_ready=0, core_rst=1.
- start -> COLLECT with addr=BASE_ADDR, byte_count=0, done=0, error=0.
REQ-007 COLLECT SHALL set in_ready=1 and accept a byte on in_valid&&in_ready; byte k of a word (k=0..3) SHALL fill wdata bits [31-8k:24-8k] (big-endian).
REQ-008 On the 4th accepted byte, COLLECT SHALL go to WR_WORD next cycle with size=10.
REQ-009 On in_last with a partial word, COLLECT SHALL take the following residual path:
- 1 byte -> WR_BYTE.
- 2 bytes -> WR_HALF.
- 3 bytes -> WR_HALF (bytes 0-1) then WR_BYTE (byte 2 at addr+2).
- Residual data SHALL be right-justified: byte in [7:0], halfword in [15:0].
REQ-010 in_last together with a 4th byte SHALL go to WR_WORD and then DONE.
REQ-011 In each WR_* state, in_ready SHALL be 0, mem_data_req=1 and mem_data_we=1, with addr/wdata/size held stable until the cycle req&&ack is seen at posedge.
REQ-012 mem_data_req SHALL deassert in the cycle after ack; back-to-back writes SHALL have at least one idle cycle between req pulses.
REQ-013 On completion of a WR_* state, addr and byte_count SHALL each advance by 4, 2 or 1 according to the size written.
REQ-014 If a write would exceed MEM_SIZE_BYTES-1 (addr+size_bytes > MEM_SIZE_BYTES), the block SHALL go to ERR before asserting req and SHALL issue no write.
REQ-015 start SHALL be ignored outside IDLE, DONE and ERR.
REQ-016 In DONE, core_rst=0 and done=1; in ERR, core_rst=1 and error=1.
REQ-017 start in DONE or ERR SHALL re-enter COLLECT as in REQ-006, with core_rst=1 from the next cycle.
REQ-018 in_last SHALL be ignored when in_valid=0; in_data SHALL be ignored unless in_valid&&in_ready.
REQ-019 byte_count SHALL wrap modulo 2^32.

Reset
REQ-020 While rst=0, regardless of state or in-flight transfer, the block SHALL set:
- state=IDLE
- mem_data_req=0, mem_data_we=0, mem_data_addr=0, mem_data_wdata=0, mem_data_size=00
- in_ready=0, core_rst=1, done=0, error=0, byte_count=0
REQ-021 A request abandoned by reset SHALL NOT be reissued after reset release.

Verification
REQ-022 Scenario 1: start, then bytes 00 09 01 00 05 02 09 02 01 00 12 with last on 0x12, ack 1 cycle after req -> the following writes in order, then done=1, core_rst=0, byte_count=11:
- word 0x00090100 @0x0
- word 0x05020902 @0x4
- halfword 0x0100 @0x8
- byte 0x12 @0xA
REQ-023 Scenario 2: ack delayed 5 cycles -> req/addr/wdata stable for all 5 cycles, in_ready=0 throughout, exactly one write per transfer.
REQ-024 Scenario 3: MEM_SIZE_BYTES=8, 9-byte image -> 2 word writes, then ERR with error=1, core_rst=1, no third req.
REQ-025 Scenario 4: rst=0 during WR_WORD with ack pending -> all outputs at reset values within the cycle; after rst=1, no req until the next start.
REQ-026 Scenario 5: single byte 0xAB with last -> one byte write 0x000000AB @BASE_ADDR, done=1, byte_count=1.
REQ-027 Scenario 6: in_valid toggling every other cycle with start asserted mid-load -> data identical to Scenario 1 and start ignored.
